// File: rtl/rf_access_arbiter.sv
`default_nettype none
// ============================================================================
// rf_access_arbiter : register-file command port owner with write-back FIFO
// Revision: 1.0
// ============================================================================
module rf_access_arbiter #(
   parameter int LEN   = 32,
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rdy_in,
   input  logic                      rd_req,
   input  logic [4:0]                rd_rs1,
   input  logic [4:0]                rd_rs2,
   output logic                      rd_grant,
   output logic                      rs_valid,
   input  logic                      wb_valid,
   input  logic [4:0]                wb_rd,
   input  logic [LEN-1:0]            wb_data,
   output logic                      wb_ready,
   output logic [1:0]                rf_signal,
   output logic [4:0]                rf_rs1,
   output logic [4:0]                rf_rs2,
   output logic [4:0]                rf_rd,
   output logic [LEN-1:0]            rf_data,
   output logic [$clog2(DEPTH):0]    pending
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [1:0]  SIG_NOP   = 2'd0;
   localparam logic [1:0]  SIG_READ  = 2'd1;
   localparam logic [1:0]  SIG_WRITE = 2'd2;
   localparam logic [PW:0] FULL_CNT  = (PW+1)'(DEPTH);

   logic [4:0]       fifo_rd   [DEPTH];
   logic [LEN-1:0]   fifo_data [DEPTH];
   logic [DEPTH-1:0] slot_valid;
   logic [PW-1:0]    head;
   logic [PW-1:0]    tail;
   logic [PW:0]      count;

   logic push;
   logic hit1;
   logic hit2;
   logic hazard;
   logic do_read;
   logic do_write;

   assign wb_ready = rdy_in && (count < FULL_CNT);
   assign push     = wb_valid && wb_ready && (wb_rd != 5'd0);
   assign pending  = count;

   // Any occupied slot naming a requested source register blocks the read.
   always_comb begin
      hit1 = 1'b0;
      hit2 = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (slot_valid[i] && (fifo_rd[i] == rd_rs1)) hit1 = 1'b1;
         if (slot_valid[i] && (fifo_rd[i] == rd_rs2)) hit2 = 1'b1;
      end
      if (push && (wb_rd == rd_rs1)) hit1 = 1'b1;
      if (push && (wb_rd == rd_rs2)) hit2 = 1'b1;
   end

   assign hazard = rd_req && (((rd_rs1 != 5'd0) && hit1) ||
                              ((rd_rs2 != 5'd0) && hit2));

   always_comb begin
      do_read  = 1'b0;
      do_write = 1'b0;
      if (rdy_in) begin
         if (count == FULL_CNT)        do_write = 1'b1;
         else if (rd_req && !hazard)   do_read  = 1'b1;
         else if (count != '0)         do_write = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_rd[tail]   <= wb_rd;
         fifo_data[tail] <= wb_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         slot_valid <= '0;
         rf_signal  <= SIG_NOP;
         rf_rs1     <= '0;
         rf_rs2     <= '0;
         rf_rd      <= '0;
         rf_data    <= '0;
         rd_grant   <= 1'b0;
         rs_valid   <= 1'b0;
      end else begin
         // The read latch is already loaded, so rs_valid follows even in a stall.
         rs_valid <= rd_grant;
         rd_grant <= do_read;
         if (do_read) begin
            rf_signal <= SIG_READ;
            rf_rs1    <= rd_rs1;
            rf_rs2    <= rd_rs2;
         end else if (do_write) begin
            rf_signal <= SIG_WRITE;
            rf_rd     <= fifo_rd[head];
            rf_data   <= fifo_data[head];
         end else begin
            rf_signal <= SIG_NOP;
         end
         if (do_write) begin
            slot_valid[head] <= 1'b0;
            head             <= head + PW'(1);
         end
         if (push) begin
            slot_valid[tail] <= 1'b1;
            tail             <= tail + PW'(1);
         end
         case ({push, do_write})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rf_access_arbiter.sv
`default_nettype none
// ============================================================================
// tb_rf_access_arbiter : scoreboard bench with queue-based reference model
// Revision: 1.0
// ============================================================================
module tb_rf_access_arbiter;

   localparam int LEN   = 32;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic           clk      = 1'b0;
   logic           rst      = 1'b0;
   logic           rdy_in   = 1'b0;
   logic           rd_req   = 1'b0;
   logic [4:0]     rd_rs1   = '0;
   logic [4:0]     rd_rs2   = '0;
   logic           wb_valid = 1'b0;
   logic [4:0]     wb_rd    = '0;
   logic [LEN-1:0] wb_data  = '0;
   logic           rd_grant;
   logic           rs_valid;
   logic           wb_ready;
   logic [1:0]     rf_signal;
   logic [4:0]     rf_rs1;
   logic [4:0]     rf_rs2;
   logic [4:0]     rf_rd;
   logic [LEN-1:0] rf_data;
   logic [CW-1:0]  pending;

   rf_access_arbiter #(.LEN(LEN), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .rdy_in(rdy_in),
      .rd_req(rd_req), .rd_rs1(rd_rs1), .rd_rs2(rd_rs2),
      .rd_grant(rd_grant), .rs_valid(rs_valid),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
      .rf_signal(rf_signal), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
      .rf_rd(rf_rd), .rf_data(rf_data), .pending(pending)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]     sig;
      logic [4:0]     rs1;
      logic [4:0]     rs2;
      logic [4:0]     rd;
      logic [LEN-1:0] data;
      logic           grant;
      logic           rsv;
      int             cnt;
   } exp_t;

   typedef struct {
      logic [4:0]     rd;
      logic [LEN-1:0] data;
   } ent_t;

   exp_t exp_q[$];
   ent_t mq[$];
   logic m_grant = 1'b0;
   int   errors  = 0;
   int   checks  = 0;

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic bit pend_write(input logic [4:0] r);
      foreach (mq[i]) if (mq[i].rd == r) return 1'b1;
      return 1'b0;
   endfunction

   // Monitor: compares every registered output one step after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rf_signal", rf_signal, e.sig);
            if (e.sig == 2'd1) begin
               check("rf_rs1", rf_rs1, e.rs1);
               check("rf_rs2", rf_rs2, e.rs2);
            end
            if (e.sig == 2'd2) begin
               check("rf_rd", rf_rd, e.rd);
               check("rf_data", rf_data, e.data);
            end
            check("rd_grant", rd_grant, e.grant);
            check("rs_valid", rs_valid, e.rsv);
            check("pending", pending, e.cnt);
         end
      end
   end

   // One cycle of stimulus; the model predicts the outcome of the next edge.
   task automatic drive(input bit r, input bit req, input logic [4:0] s1,
                        input logic [4:0] s2, input bit wv, input logic [4:0] wr,
                        input logic [LEN-1:0] wd, output bit granted);
      exp_t e;
      ent_t h;
      bit   push;
      bit   hz;
      int   n;
      @(negedge clk);
      rdy_in = r; rd_req = req; rd_rs1 = s1; rd_rs2 = s2;
      wb_valid = wv; wb_rd = wr; wb_data = wd;
      #1;
      n = mq.size();
      check("wb_ready", wb_ready, r && (n < DEPTH));
      e.sig = 2'd0; e.rs1 = s1; e.rs2 = s2; e.rd = '0; e.data = '0;
      e.grant = 1'b0; e.rsv = m_grant;
      push = r && wv && (n < DEPTH) && (wr != 5'd0);
      hz = req && (((s1 != 5'd0) && (pend_write(s1) || (push && wr == s1))) ||
                   ((s2 != 5'd0) && (pend_write(s2) || (push && wr == s2))));
      if (r) begin
         if (n == DEPTH || (!(req && !hz) && n > 0)) begin
            h = mq.pop_front();
            e.sig = 2'd2; e.rd = h.rd; e.data = h.data;
         end else if (req && !hz) begin
            e.sig = 2'd1; e.grant = 1'b1;
         end
      end
      if (push) mq.push_back('{wr, wd});
      e.cnt   = mq.size();
      m_grant = e.grant;
      granted = e.grant;
      exp_q.push_back(e);
   endtask

   task automatic idle(input int cycles);
      bit g;
      for (int i = 0; i < cycles; i++) drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, g);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0; rdy_in = 1'b0; rd_req = 1'b0; wb_valid = 1'b0;
      #1;
      check("rst_rf_signal", rf_signal, 0);
      check("rst_pending", pending, 0);
      check("rst_rd_grant", rd_grant, 0);
      check("rst_rs_valid", rs_valid, 0);
      mq.delete();
      exp_q.delete();
      m_grant = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1; rdy_in = 1'b1;
      #1;
      check("rst_wb_ready", wb_ready, 1);
   endtask

   initial begin
      bit         g;
      bit         have_req;
      logic [4:0] s1;
      logic [4:0] s2;
      int         guard;

      do_reset();
      // First read after reset, then its rs_valid pulse.
      drive(1'b1, 1'b1, 5'd3, 5'd5, 1'b0, '0, '0, g);
      idle(2);
      // Single write-back drains immediately.
      drive(1'b1, 1'b0, '0, '0, 1'b1, 5'd7, 32'hDEADBEEF, g);
      idle(2);
      // Read of a register being written in the same cycle waits for the write.
      g = 1'b0;
      drive(1'b1, 1'b1, 5'd4, 5'd0, 1'b1, 5'd4, 32'h4444_0004, g);
      guard = 0;
      while (!g && guard < 10) begin
         drive(1'b1, 1'b1, 5'd4, 5'd0, 1'b0, '0, '0, g);
         guard++;
      end
      check("hazard_read_issued", g, 1);
      idle(2);
      // Fill the FIFO behind a held read; full forces a write first.
      for (int i = 1; i <= 4; i++)
         drive(1'b1, 1'b1, 5'd9, 5'd10, 1'b1, 5'(i), 32'hA000_0000 + i, g);
      drive(1'b1, 1'b1, 5'd9, 5'd10, 1'b1, 5'd20, 32'h5555, g);
      drive(1'b1, 1'b1, 5'd9, 5'd10, 1'b0, '0, '0, g);
      idle(6);
      // Write-back to x0 completes without storing.
      drive(1'b1, 1'b0, '0, '0, 1'b1, 5'd0, 32'h1234, g);
      idle(2);
      // Stall with two queued writes and a pending read.
      drive(1'b1, 1'b1, 5'd9, 5'd10, 1'b1, 5'd11, 32'hB11, g);
      drive(1'b1, 1'b1, 5'd9, 5'd10, 1'b1, 5'd12, 32'hB12, g);
      for (int i = 0; i < 3; i++)
         drive(1'b0, 1'b1, 5'd9, 5'd10, 1'b1, 5'd13, 32'hB13, g);
      drive(1'b1, 1'b1, 5'd9, 5'd10, 1'b0, '0, '0, g);
      idle(4);
      // Reset with three writes queued.
      for (int i = 0; i < 3; i++)
         drive(1'b1, 1'b1, 5'd9, 5'd10, 1'b1, 5'(13 + i), 32'hC000 + i, g);
      check("model_count_before_reset", mq.size(), 3);
      do_reset();
      idle(2);
      // Randomised traffic with small register indices to provoke hazards.
      have_req = 1'b0; s1 = '0; s2 = '0;
      for (int i = 0; i < 2000; i++) begin
         if (!have_req && ($urandom_range(0, 2) != 0)) begin
            have_req = 1'b1;
            s1 = 5'($urandom_range(0, 7));
            s2 = 5'($urandom_range(0, 7));
         end
         drive($urandom_range(0, 9) != 0, have_req, s1, s2,
               $urandom_range(0, 1) != 0, 5'($urandom_range(0, 7)), $urandom, g);
         if (g) have_req = 1'b0;
      end
      idle(8);
      @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
